// File: rtl/uart_frame_check_pkg.sv
// Shared types for the UART receive path: frame-check FSM states and parity-type codes.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Bit counter must reach DATA_W itself, hence the +1.
  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/uart_frame_check_if.sv
// Bus between the oversampler/host side (master) and the frame checker (slave).
// Counter signals exist only when UART_ERR_CNT_EN is defined.
interface uart_frame_check_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);

  logic              bit_vld;
  logic              sampled_bit;
  logic              par_en;
  logic              par_typ;
  logic              frame_abort;
  logic [DATA_W-1:0] data_out;
  logic              data_vld;
  logic              par_err;
  logic              stop_err;
  logic              start_glitch;
  logic              busy;
`ifdef UART_ERR_CNT_EN
  logic              cnt_clr;
  logic [CNT_W-1:0]  par_err_cnt;
  logic [CNT_W-1:0]  stop_err_cnt;
`else
  logic [CNT_W-1:0]  w_unused_cnt_w;
  assign w_unused_cnt_w = '0;
`endif

  modport master (
    output bit_vld, sampled_bit, par_en, par_typ, frame_abort,
    input  data_out, data_vld, par_err, stop_err, start_glitch, busy
`ifdef UART_ERR_CNT_EN
    , output cnt_clr
    , input  par_err_cnt, stop_err_cnt
`endif
  );

  modport slave (
    input  bit_vld, sampled_bit, par_en, par_typ, frame_abort,
    output data_out, data_vld, par_err, stop_err, start_glitch, busy
`ifdef UART_ERR_CNT_EN
    , input  cnt_clr
    , output par_err_cnt, stop_err_cnt
`endif
  );

endinterface

// File: rtl/uart_frame_check_parity_calc.sv
// Combinational parity of a data word; output is the parity bit the line should carry.
module uart_parity_calc
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_par_typ,
  output logic              o_par_bit
);

  logic [DATA_W:0] w_chain;

  assign w_chain[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_xor
      assign w_chain[gi+1] = w_chain[gi] ^ i_data[gi];
    end
  endgenerate

  assign o_par_bit = w_chain[DATA_W] ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/uart_frame_check.sv
// UART frame checker: assembles start/data/parity/stop bits from bit_vld strobes and flags errors.
// Define UART_ERR_CNT_EN to add saturating parity/stop error counters and cnt_clr.
module uart_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 8
) (
  input logic              clk,
  input logic              rst,
  uart_frame_check_if.slave bus
);

  localparam int BC_W = bit_cnt_w(DATA_W);

  rx_state_t         r_state;
  rx_state_t         w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [BC_W-1:0]   w_bit_cnt_next;
  logic              r_par_en;
  logic              w_par_en_next;
  logic              r_par_typ;
  logic              w_par_typ_next;
  logic              r_par_fail;
  logic              w_par_fail_next;
  logic              r_stop_fail;
  logic              w_stop_fail_next;
  logic [DATA_W-1:0] r_data_out;
  logic [DATA_W-1:0] w_data_out_next;
  logic              r_par_err;
  logic              w_par_err_next;
  logic              r_stop_err;
  logic              w_stop_err_next;
  logic              r_data_vld;
  logic              w_data_vld_next;
  logic              r_glitch;
  logic              w_glitch_next;
  logic              w_done;
  logic              w_par_exp;
  logic              w_stop_fail_now;

  uart_parity_calc #(
    .DATA_W (DATA_W)
  ) u_parity_calc (
    .i_data    (r_shift),
    .i_par_typ (r_par_typ),
    .o_par_bit (w_par_exp)
  );

  // Includes the stop bit being sampled this cycle, so completion can report it without delay.
  assign w_stop_fail_now = r_stop_fail | ~bus.sampled_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_bit_cnt_next   = r_bit_cnt;
    w_par_en_next    = r_par_en;
    w_par_typ_next   = r_par_typ;
    w_par_fail_next  = r_par_fail;
    w_stop_fail_next = r_stop_fail;
    w_data_out_next  = r_data_out;
    w_par_err_next   = r_par_err;
    w_stop_err_next  = r_stop_err;
    w_data_vld_next  = 1'b0;
    w_glitch_next    = 1'b0;
    w_done           = 1'b0;

    if (bus.frame_abort) begin
      w_state_next = IDLE;
      // A frame aborted before its first data bit is reported as a false start.
      if (r_state == DATA && r_bit_cnt == '0) begin
        w_glitch_next = 1'b1;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.bit_vld && !bus.sampled_bit) begin
            w_state_next = START;
          end
        end
        START: begin
          w_state_next     = DATA;
          w_bit_cnt_next   = '0;
          w_par_en_next    = bus.par_en;
          w_par_typ_next   = bus.par_typ;
          w_par_fail_next  = 1'b0;
          w_stop_fail_next = 1'b0;
        end
        DATA: begin
          if (bus.bit_vld) begin
            w_shift_next   = {bus.sampled_bit, r_shift[DATA_W-1:1]};
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            if (r_bit_cnt == BC_W'(DATA_W - 1)) begin
              w_state_next = r_par_en ? PARITY : STOP1;
            end
          end
        end
        PARITY: begin
          if (bus.bit_vld) begin
            if (bus.sampled_bit != w_par_exp) begin
              w_par_fail_next = 1'b1;
            end
            w_state_next = STOP1;
          end
        end
        STOP1: begin
          if (bus.bit_vld) begin
            w_stop_fail_next = w_stop_fail_now;
            if (STOP_BITS == 2) begin
              w_state_next = STOP2;
            end else begin
              w_done = 1'b1;
            end
          end
        end
        STOP2: begin
          if (bus.bit_vld) begin
            w_stop_fail_next = w_stop_fail_now;
            w_done           = 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end

    if (w_done) begin
      w_state_next    = IDLE;
      w_data_out_next = r_shift;
      w_par_err_next  = r_par_fail;
      w_stop_err_next = w_stop_fail_now;
      w_data_vld_next = ~r_par_fail & ~w_stop_fail_now;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par_en    <= 1'b0;
      r_par_typ   <= PAR_EVEN;
      r_par_fail  <= 1'b0;
      r_stop_fail <= 1'b0;
      r_data_out  <= '0;
      r_par_err   <= 1'b0;
      r_stop_err  <= 1'b0;
      r_data_vld  <= 1'b0;
      r_glitch    <= 1'b0;
    end else begin
      r_shift     <= w_shift_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_par_en    <= w_par_en_next;
      r_par_typ   <= w_par_typ_next;
      r_par_fail  <= w_par_fail_next;
      r_stop_fail <= w_stop_fail_next;
      r_data_out  <= w_data_out_next;
      r_par_err   <= w_par_err_next;
      r_stop_err  <= w_stop_err_next;
      r_data_vld  <= w_data_vld_next;
      r_glitch    <= w_glitch_next;
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.data_vld     = r_data_vld;
  assign bus.par_err      = r_par_err;
  assign bus.stop_err     = r_stop_err;
  assign bus.start_glitch = r_glitch;
  assign bus.busy         = (r_state != IDLE);

`ifdef UART_ERR_CNT_EN
  logic [1:0] w_cnt_inc;

  assign w_cnt_inc[0] = w_done & r_par_fail;
  assign w_cnt_inc[1] = w_done & w_stop_fail_now;

  // Index 0 counts parity errors, index 1 stop errors; clear wins over increment.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_err_cnt
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (bus.cnt_clr) begin
          r_cnt <= '0;
        end else if (w_cnt_inc[gi] && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign bus.par_err_cnt  = g_err_cnt[0].r_cnt;
  assign bus.stop_err_cnt = g_err_cnt[1].r_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: doc/uart_frame_check.md
UART_FRAME_CHECK -- requirements
Module: uart_frame_check

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data bits per frame (legal 5..9).
REQ-002 Parameter STOP_BITS, default 1, SHALL set the stop bits checked per frame (legal 1 or 2).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of each error counter.
REQ-004 clk  input  1  block clock.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 bit_vld  input  1  one-cycle strobe marking a valid sampled_bit from the oversampler.
REQ-007 sampled_bit  input  1  majority-voted line value, qualified by bit_vld.
REQ-008 par_en  input  1  parity bit present in the frame.
REQ-009 par_typ  input  1  parity type: 0 = even, 1 = odd.
REQ-010 frame_abort  input  1  synchronous abort of the current frame.
REQ-011 data_out  output  DATA_W  received data, LSB first on the line.
REQ-012 data_vld  output  1  one-cycle pulse: a frame completed with no error.
REQ-013 par_err  output  1  parity error of the last frame; held until the next frame completes.
REQ-014 stop_err  output  1  stop error of the last frame (either stop bit low); held until the next frame completes.
REQ-015 start_glitch  output  1  one-cycle pulse: start bit sampled high.
REQ-016 busy  output  1  high while the FSM is not IDLE.
REQ-017 par_err_cnt, stop_err_cnt  output  CNT_W each  saturating error counts (ERR_CNT_EN builds only).
REQ-018 cnt_clr  input  1  synchronous clear of both counters (ERR_CNT_EN builds only).

Function
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2, and the FSM SHALL advance only on cycles with bit_vld=1.
REQ-020 In IDLE, a cycle with bit_vld=1 and sampled_bit=0 SHALL move the FSM to START; that bit is the start bit.
REQ-021 START SHALL be a transient one-cycle state that moves to DATA; the first data bit is the next bit_vld.
REQ-022 DATA SHALL shift sampled_bit into the MSB of a DATA_W register (right shift), count DATA_W bits, then go to PARITY if par_en=1, else STOP1.
REQ-023 PARITY SHALL compare sampled_bit against the XOR of the data bits, inverted when par_typ=1; a mismatch SHALL set an internal par_fail flag.
REQ-024 STOP1 SHALL set an internal stop_fail flag if sampled_bit=0, then go to STOP2 if STOP_BITS=2, else complete.
REQ-025 STOP2 SHALL set stop_fail if sampled_bit=0, then complete.
REQ-026 On completion, the block SHALL: load data_out, par_err and stop_err in the cycle after the final stop bit_vld; pulse data_vld in that same cycle only if both flags are clear; return to IDLE.
REQ-027 data_out SHALL be loaded even on an errored frame, and SHALL hold its value between completions.
REQ-028 A start_glitch condition (START entered with sampled_bit=1) is unreachable by REQ-020. The IDLE entry check SHALL therefore be validated on the next bit_vld instead: if the FSM is in DATA with bit count 0 and frame_abort is asserted, start_glitch SHALL pulse.
REQ-029 frame_abort=1 SHALL force IDLE on the next edge and discard the partial frame: no data_vld, flags unchanged; abort SHALL take priority over bit_vld in the same cycle.
REQ-030 par_en and par_typ SHALL be sampled at START and held for the frame; changes mid-frame SHALL have no effect.
REQ-031 Bit-count arithmetic SHALL use a $clog2(DATA_W+1)-bit counter with no wrap beyond DATA_W.

Reset
REQ-032 rst low SHALL immediately force: FSM = IDLE; data_out = 0; data_vld, par_err, stop_err, start_glitch and busy = 0; counters = 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a new start bit.

Configuration
REQ-034 Macro UART_ERR_CNT_EN defined SHALL include par_err_cnt, stop_err_cnt and cnt_clr; each counter SHALL increment once per completed frame with the matching error and saturate at 2^CNT_W-1.
REQ-035 cnt_clr SHALL take priority over an increment in the same cycle.
REQ-036 Without UART_ERR_CNT_EN, those ports and the counter logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-037 Shared package uart_rx_pkg SHALL hold the FSM state typedef and the parity-type constants PAR_EVEN=0 and PAR_ODD=1.
REQ-038 Parity computation SHALL be a sub-module uart_parity_calc (DATA_W-parameterised, combinational XOR with par_typ inversion).

Verification
REQ-039 DATA_W=8, no parity, 1 stop: send 0xA5 with stop=1 -> data_vld pulses once, data_out=0xA5, par_err=0, stop_err=0.
REQ-040 par_en=1, par_typ=0: send 0x07 with parity bit 0 (expected 1) -> par_err=1, data_vld=0, data_out=0x07, par_err_cnt=1.
REQ-041 STOP_BITS=2: send 0x3C with stop1=1, stop2=0 -> stop_err=1, no data_vld; next good frame 0x55 -> stop_err=0, data_vld=1.
REQ-042 frame_abort asserted after 4 data bits, coincident with bit_vld -> IDLE next cycle, busy=0, no data_vld, flags unchanged.
REQ-043 rst pulsed low mid-DATA -> all outputs 0 immediately; next frame 0x81 received correctly.
REQ-044 UART_ERR_CNT_EN, CNT_W=2: send 5 stop-error frames -> stop_err_cnt saturates at 3; cnt_clr coincident with a 6th error -> count = 0.
